// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, writes it into instruction
// memory, then releases the core. Define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    // Handshake: a byte moves on a rising clk edge where rx_valid and rx_ready are both high;
    // rx_ready is high exactly while the loader is in a receiving state.
    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = RUN;
`endif
    localparam logic [16:0] DEPTH17 = 17'(DEPTH);

    state_t      state, nxt;
    logic [15:0] n;
    logic [15:0] wcnt;
    logic [1:0]  byte_cnt;
    logic [23:0] part;
    logic        xfer;
    logic [15:0] n_full;
    logic        last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    assign state_dbg = state;

    always_comb begin
        xfer      = rx_valid && rx_ready;
        n_full    = {rx_data, n[7:0]};
        last_byte = (byte_cnt == 2'd3) && ((wcnt + 16'd1) == n);
        nxt       = state;
        case (state)
            HDR0: if (xfer) nxt = HDR1;
            HDR1: begin
                if (xfer) begin
                    if ({1'b0, n_full} > DEPTH17) nxt = ERROR;
                    else if (n_full == 16'd0)     nxt = AFTER_DATA;
                    else                          nxt = DATA;
                end
            end
            DATA: if (xfer && last_byte) nxt = AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (xfer) nxt = (sum == rx_data) ? RUN : ERROR;
`endif
            RUN, ERROR: if (reload) nxt = HDR0;
            default: nxt = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HDR0;
            rx_ready   <= 1'b1;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            n          <= '0;
            wcnt       <= '0;
            byte_cnt   <= '0;
            part       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state    <= nxt;
            rx_ready <= (nxt != RUN) && (nxt != ERROR);
            core_rst <= (nxt != RUN);
            done     <= (nxt == RUN);
            err      <= (nxt == ERROR);
            imem_we  <= 1'b0;
            if (xfer) begin
                case (state)
                    HDR0: n[7:0]  <= rx_data;
                    HDR1: n[15:8] <= rx_data;
                    DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wcnt[ADDR_W-1:0];
                            imem_wdata <= {rx_data, part};
                            wcnt       <= wcnt + 16'd1;
                            byte_cnt   <= 2'd0;
                            part       <= '0;
                        end else begin
                            part[{byte_cnt, 3'b000} +: 8] <= rx_data;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
            // Restarting from RUN/ERROR discards everything learned about the previous image.
            if (reload && (state == RUN || state == ERROR)) begin
                n        <= '0;
                wcnt     <= '0;
                byte_cnt <= '0;
                part     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum      <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/payload framing, write strobes, run/error/reload control.
module tb_imem_loader;

  localparam int AW = 10;
  localparam logic [2:0] S_HDR0 = 3'd0, S_HDR1 = 3'd1, S_RUN = 3'd4, S_ERROR = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [2:0]    state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int stalls = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  logic [31:0]    img[$];

  imem_loader #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // write monitor, sampled mid-cycle
  always @(negedge clk) if (imem_we) got_q.push_back({imem_addr, imem_wdata});

  // drivers
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    if (!rx_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_byte timeout: rx_ready=%b required 1", rx_ready);
    end else begin
      @(posedge clk); #1;
      stalls += waited;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic load_image(input int max_gap);
    logic [15:0] n;
    logic [7:0]  sum;
    logic [31:0] w;
    n = 16'(img.size());
    sum = 8'h00;
    exp_q.delete(); got_q.delete();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      exp_q.push_back({AW'(i), w});
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        send_byte(w[8*k +: 8]);
        sum = sum + w[8*k +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sum);
`endif
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b0; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    tests_run++; if (state_dbg !== S_HDR0) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_HDR0); end
    tests_run++; if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    tests_run++; if (core_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    tests_run++; if ({imem_we, done, err} !== 3'b000) begin tests_failed++; $display("FAIL reset_we_done_err: got %b want 000", {imem_we, done, err}); end
    tests_run++; if ({imem_addr, imem_wdata} !== '0) begin tests_failed++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", imem_addr, imem_wdata); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    img.delete(); img.push_back(32'h00100013); img.push_back(32'h00200093);
    stalls = 0;
    load_image(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    tests_run++; if (imem_we !== 1'b1) begin tests_failed++; $display("FAIL b2b_last_we: got %b want 1", imem_we); end
`endif
    tests_run++; if (state_dbg !== S_RUN) begin tests_failed++; $display("FAIL b2b_state: got %0d want %0d", state_dbg, S_RUN); end
    @(posedge clk); #1;
    tests_run++; if (core_rst !== 1'b0) begin tests_failed++; $display("FAIL b2b_core_rst: got %b want 0", core_rst); end
    tests_run++; if (done !== 1'b1 || err !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_err: got %b%b want 10", done, err); end
    tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_rx_ready: got %b want 0", rx_ready); end
    tests_run++; if (stalls != 0) begin tests_failed++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_wr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_wr%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reload();
    // from RUN (left by the previous test): reload restarts at address 0
    pulse_reload();
    tests_run++; if (state_dbg !== S_HDR0 || core_rst !== 1'b1 || done !== 1'b0) begin
      tests_failed++; $display("FAIL reload_from_run: got st=%0d crst=%b done=%b want 0/1/0", state_dbg, core_rst, done); end
    img.delete(); img.push_back(32'hCAFEF00D);
    load_image(0);
    @(posedge clk); #1;
    tests_run++; if (got_q.size() != 1 || got_q[0] !== {AW'(0), 32'hCAFEF00D}) begin
      tests_failed++; $display("FAIL reload_rewrite: got n=%0d first=%h want 1 x %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, {AW'(0), 32'hCAFEF00D}); end
    // reload is ignored while receiving the header
    do_reset();
    send_byte(8'h05);
    pulse_reload();
    tests_run++; if (state_dbg !== S_HDR1) begin tests_failed++; $display("FAIL reload_ignored_hdr1: got %0d want %0d", state_dbg, S_HDR1); end
  endtask

  task automatic test_empty();
    do_reset();
    img.delete();
    load_image(0);
    tests_run++; if (state_dbg !== S_RUN) begin tests_failed++; $display("FAIL empty_state: got %0d want %0d", state_dbg, S_RUN); end
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b1 || core_rst !== 1'b0) begin tests_failed++; $display("FAIL empty_done: got done=%b crst=%b want 1/0", done, core_rst); end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL empty_writes: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_oversize();
    do_reset();
    got_q.delete();
    send_byte(8'h01);
    send_byte(8'h04);
    tests_run++; if (state_dbg !== S_ERROR) begin tests_failed++; $display("FAIL over_state: got %0d want %0d", state_dbg, S_ERROR); end
    tests_run++; if ({err, rx_ready, core_rst, done} !== 4'b1010) begin
      tests_failed++; $display("FAIL over_flags: got err/rdy/crst/done=%b want 1010", {err, rx_ready, core_rst, done}); end
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (3) @(posedge clk); #1;
    rx_valid = 1'b0;
    tests_run++; if (state_dbg !== S_ERROR || got_q.size() != 0) begin
      tests_failed++; $display("FAIL over_ignored: got st=%0d writes=%0d want %0d/0", state_dbg, got_q.size(), S_ERROR); end
    pulse_reload();
    tests_run++; if (state_dbg !== S_HDR0 || err !== 1'b0 || rx_ready !== 1'b1 || core_rst !== 1'b1) begin
      tests_failed++; $display("FAIL over_reload: got st=%0d err=%b rdy=%b crst=%b want 0/0/1/1", state_dbg, err, rx_ready, core_rst); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    got_q.delete();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    @(posedge clk); #1;
    tests_run++; if (state_dbg !== S_RUN || done !== 1'b1) begin tests_failed++; $display("FAIL csum_good: got st=%0d done=%b want %0d/1", state_dbg, done, S_RUN); end
    tests_run++; if (got_q.size() != 1 || got_q[0] !== {AW'(0), 32'h04030201}) begin
      tests_failed++; $display("FAIL csum_write: got n=%0d want 1 x %h", got_q.size(), {AW'(0), 32'h04030201}); end
    pulse_reload();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    tests_run++; if (state_dbg !== S_ERROR || err !== 1'b1 || core_rst !== 1'b1) begin
      tests_failed++; $display("FAIL csum_bad: got st=%0d err=%b crst=%b want %0d/1/1", state_dbg, err, core_rst, S_ERROR); end
    pulse_reload();
    tests_run++; if (state_dbg !== S_HDR0 || err !== 1'b0) begin tests_failed++; $display("FAIL csum_reload: got st=%0d err=%b want 0/0", state_dbg, err); end
  endtask
`endif

  task automatic test_random_valid();
    do_reset();
    img.delete(); img.push_back(32'h00100013); img.push_back(32'h00200093); img.push_back(32'hDEADBEEF);
    load_image(3);
    repeat (2) @(posedge clk); #1;
    tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rnd_wr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rnd_wr%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL rnd_done: got %b want 1", done); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b0;
    #1;
    tests_run++; if (state_dbg !== S_HDR0 || core_rst !== 1'b1 || imem_wdata !== 32'h0) begin
      tests_failed++; $display("FAIL midrst_async: got st=%0d crst=%b wdata=%h want 0/1/0", state_dbg, core_rst, imem_wdata); end
    rx_valid = 1'b1; rx_data = 8'hFF;
    repeat (2) @(posedge clk); #1;
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (state_dbg !== S_HDR0) begin tests_failed++; $display("FAIL midrst_no_xfer: got %0d want 0", state_dbg); end
    img.delete(); img.push_back(32'h88776655);
    load_image(0);
    repeat (2) @(posedge clk); #1;
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL midrst_wr_count: got %0d want 1", got_q.size()); end
    tests_run++; if (got_q.size() > 0 && got_q[0] !== {AW'(0), 32'h88776655}) begin
      tests_failed++; $display("FAIL midrst_wr0: got %h want %h", got_q[0], {AW'(0), 32'h88776655}); end
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
    test_reset();
    test_back_to_back();
    test_reload();
    test_empty();
    test_oversize();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random_valid();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
